// File: rtl/pwm_pkg.sv
// Shared defaults and types for the phased-array PWM controller.
package pwm_pkg;

  localparam int DEF_N_CH   = 8;
  localparam int DEF_CNT_W  = 10;
  localparam int DEF_PERIOD = 675;

  typedef enum logic [1:0] {IDLE, PENDING, APPLY} ctrl_state_t;

  typedef logic [DEF_CNT_W-1:0] phase_t;

endpackage

// File: rtl/pwm_phase_cmp.sv
// One channel: phase-shifted position within the period, compared against
// half the period to give a registered 50 % duty square wave.
module pwm_phase_cmp
  import pwm_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int PERIOD = DEF_PERIOD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [CNT_W-1:0] ph_i,
  output logic             pwm_o
);

  localparam logic [CNT_W:0] PER_E = (CNT_W+1)'(PERIOD);
  localparam logic [CNT_W:0] HALF  = (CNT_W+1)'(PERIOD / 2);

  logic [CNT_W:0] d;
  logic           pwm_q;

  // One extra bit so cnt + PERIOD cannot overflow before the subtract.
  always_comb begin
    if ({1'b0, cnt_i} >= {1'b0, ph_i}) d = {1'b0, cnt_i} - {1'b0, ph_i};
    else                               d = {1'b0, cnt_i} + PER_E - {1'b0, ph_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= 1'b0;
    else        pwm_q <= enable_i & (d < HALF);
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_phase_ctrl.sv
// Eight-channel phased PWM: shared period counter, shadow/active phase banks
// and a scheduler that swaps all phases together at a period wrap.
module pwm_phase_ctrl
  import pwm_pkg::*;
#(
  parameter  int N_CH   = DEF_N_CH,
  parameter  int CNT_W  = DEF_CNT_W,
  parameter  int PERIOD = DEF_PERIOD,
  localparam int CH_W   = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_phase,
  input  logic             commit,
  output logic             busy,
  output logic [N_CH-1:0]  pwm_o,
  output logic [N_CH-1:0]  change_pwm,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W:0]   PER_E = (CNT_W+1)'(PERIOD);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shadow_q [N_CH];
  logic [CNT_W-1:0] ph_q     [N_CH];
  logic [N_CH-1:0]  change_q, change_d;
  logic             wrap, apply, wr_fire;

  function automatic logic [CNT_W-1:0] sat_phase(input logic [CNT_W-1:0] p);
    if ({1'b0, p} >= PER_E) return LAST;
    return p;
  endfunction

  assign wrap    = enable & (cnt_q == LAST);
  assign busy    = (state_q != IDLE);
  assign wr_ready = ~busy;
  assign wr_fire = wr_valid & wr_ready;

  always_comb begin
    cnt_d = '0;
    if (enable) cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    apply   = 1'b0;
    case (state_q)
      IDLE:    if (commit) state_d = PENDING;
      PENDING: if (wrap || !enable) begin
        state_d = APPLY;
        apply   = 1'b1;
      end
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    change_d = '0;
    for (int i = 0; i < N_CH; i++) change_d[i] = apply & (shadow_q[i] != ph_q[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      change_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      change_q <= change_d;
    end
  end

  // Channel indices beyond N_CH match no entry, so such writes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        shadow_q[i] <= '0;
        ph_q[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wr_fire && (wr_ch == CH_W'(i))) shadow_q[i] <= sat_phase(wr_phase);
        if (apply) ph_q[i] <= shadow_q[i];
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pwm_phase_cmp #(
      .CNT_W  (CNT_W),
      .PERIOD (PERIOD)
    ) u_cmp (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable_i (enable),
      .cnt_i    (cnt_q),
      .ph_i     (ph_q[g]),
      .pwm_o    (pwm_o[g])
    );
  end

  assign cnt_o      = cnt_q;
  assign change_pwm = change_q;

endmodule

// File: tb/tb_pwm_phase_ctrl.sv
// Directed bench for pwm_phase_ctrl at PERIOD=16, CNT_W=5.
module tb_pwm_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, enable, wr_valid, wr_ready, commit, busy;
  logic [2:0] wr_ch;
  logic [4:0] wr_phase, cnt_o;
  logic [7:0] pwm_o, change_pwm;

  int checks = 0;
  int errors = 0;

  // Per-channel windows: bit c set when pwm is high for lagged count c.
  logic [15:0] mask      [8];
  logic [15:0] mask_next [8];

  pwm_phase_ctrl #(.N_CH(8), .CNT_W(5), .PERIOD(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_ch      (wr_ch),
    .wr_phase   (wr_phase),
    .commit     (commit),
    .busy       (busy),
    .pwm_o      (pwm_o),
    .change_pwm (change_pwm),
    .cnt_o      (cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    logic [4:0] cb;
    logic       eb;
    logic [7:0] ep;
    cb = cnt_o;
    eb = enable;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) ep[i] = eb & mask[i][cb];
    check("pwm", pwm_o, ep);
    check("cnt", cnt_o, eb ? ((cb == 5'd15) ? 5'd0 : cb + 5'd1) : 5'd0);
  endtask

  task automatic write_ph(input logic [2:0] ch, input logic [4:0] ph, input logic [15:0] msk);
    wr_valid = 1'b1;
    wr_ch    = ch;
    wr_phase = ph;
    check("wr_ready_idle", wr_ready, 1'b1);
    tick();
    wr_valid = 1'b0;
    mask_next[ch] = msk;
  endtask

  task automatic commit_at(input logic [4:0] at_cnt, input logic [7:0] exp_chg,
                           input logic hold_wr, input logic co_wr);
    int n;
    n = 0;
    while (cnt_o != at_cnt && n < 40) begin
      tick();
      n++;
    end
    check("cnt_reach", n < 40, 1'b1);
    commit = 1'b1;
    if (co_wr) begin
      wr_valid = 1'b1;
      wr_ch    = 3'd0;
      wr_phase = 5'd8;
    end
    tick();
    commit   = 1'b0;
    wr_valid = 1'b0;
    if (co_wr) mask_next[0] = 16'hFF00;
    if (hold_wr) begin
      wr_valid = 1'b1;
      wr_ch    = 3'd1;
      wr_phase = 5'd8;
    end
    n = 0;
    do begin
      check("busy_pend", busy, 1'b1);
      check("chg_pend", change_pwm, 8'h00);
      check("wr_ready_pend", wr_ready, 1'b0);
      tick();
      n++;
    end while (cnt_o != 5'd0 && n < 40);
    check("wrap_reach", n < 40, 1'b1);
    check("chg_apply", change_pwm, exp_chg);
    check("busy_apply", busy, 1'b1);
    for (int i = 0; i < 8; i++) mask[i] = mask_next[i];
    tick();
    check("chg_clear", change_pwm, 8'h00);
    check("busy_clear", busy, 1'b0);
    check("wr_ready_back", wr_ready, 1'b1);
    if (hold_wr) begin
      tick();
      wr_valid = 1'b0;
      mask_next[1] = 16'hFF00;
    end
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    enable   = 1'b0;
    wr_valid = 1'b0;
    wr_ch    = '0;
    wr_phase = '0;
    commit   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mask[i]      = 16'h00FF;
      mask_next[i] = 16'h00FF;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_pwm", pwm_o, 8'h00);
    check("rst_chg", change_pwm, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_cnt", cnt_o, 5'd0);

    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (32) tick();

    write_ph(3'd3, 5'd4, 16'h0FF0);
    commit_at(5'd2, 8'h08, 1'b0, 1'b0);
    repeat (20) tick();

    write_ph(3'd5, 5'd20, 16'h807F);
    commit_at(5'd5, 8'h20, 1'b0, 1'b0);
    repeat (20) tick();

    // Write held across a busy window: stalled, then lands after APPLY.
    commit_at(5'd3, 8'h00, 1'b1, 1'b0);
    repeat (20) tick();

    // Commit in the wrap cycle itself, with a same-cycle write folded in.
    commit_at(5'd15, 8'h03, 1'b0, 1'b1);
    repeat (20) tick();

    commit_at(5'd2, 8'h00, 1'b0, 1'b0);
    repeat (4) tick();

    write_ph(3'd7, 5'd2, 16'h03FC);
    enable = 1'b0;
    repeat (2) tick();
    commit_at(5'd0, 8'h80, 1'b0, 1'b0);
    tick();
    enable = 1'b1;
    repeat (20) tick();

    // Reset while a commit is pending.
    write_ph(3'd2, 5'd6, 16'h3FC0);
    n = 0;
    while (cnt_o != 5'd4 && n < 40) begin
      tick();
      n++;
    end
    check("cnt_reach_rst", n < 40, 1'b1);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    repeat (3) tick();
    check("busy_before_rst", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_pwm", pwm_o, 8'h00);
    check("midrst_chg", change_pwm, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_wr_ready", wr_ready, 1'b1);
    check("midrst_cnt", cnt_o, 5'd0);
    for (int i = 0; i < 8; i++) begin
      mask[i]      = 16'h00FF;
      mask_next[i] = 16'h00FF;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("post_rst_chg", change_pwm, 8'h00);
      check("post_rst_busy", busy, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
